mux_arb_nto1: RTL and testbench

Parametrised N-input, W-bit arbitrated multiplexer with valid/ready handshakes on every input and a registered output stage. It is the successor to the fixed 2-to-1 datapath muxes. It merges several producer streams, for example multiple writeback or forwarding request sources, onto one consumer with fixed-priority or round-robin selection. It has one cycle of latency and sustains one transfer per cycle.

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux_arb_nto1_if.sv | 26 ++
 rtl/arb_rr_nto1.sv | 52 +++++
 rtl/mux_arb_nto1.sv | 87 ++++++++
 tb/tb_mux_arb_nto1.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the arbitrated N-to-1 mux.
package mux_pkg;

  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} arb_mode_e;

  // Output register occupancy.
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} out_state_e;

  // $clog2 that never returns 0, so a single-input mux still has a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_nto1_if.sv
// Handshake bundle between N producers, the mux and one consumer.
//   i_data/i_valid/o_ready : producer side, input k at [k*WIDTH +: WIDTH]
//   o_data/o_sel/o_valid/i_ready : consumer side
// slave is the mux's view, master the surrounding environment's view.
interface mux_arb_nto1_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_IN  = 4
);
  import mux_pkg::*;

  localparam int unsigned SEL_W = clog2_min1(N_IN);

  logic [N_IN*WIDTH-1:0] i_data;
  logic [N_IN-1:0]       i_valid;
  logic [N_IN-1:0]       o_ready;
  logic [WIDTH-1:0]      o_data;
  logic [SEL_W-1:0]      o_sel;
  logic                  o_valid;
  logic                  i_ready;

  modport slave  (input  i_data, i_valid, i_ready,
                  output o_ready, o_data, o_sel, o_valid);
  modport master (output i_data, i_valid, i_ready,
                  input  o_ready, o_data, o_sel, o_valid);

endinterface

// File: rtl/arb_rr_nto1.sv
// Grant logic and round-robin pointer.
//   clk, rst   : clock, async active-high reset
//   mode       : fixed priority or round-robin
//   req        : request vector
//   advance    : a grant was taken this cycle
//   gnt_idx    : granted index (combinational)
//   gnt_valid  : at least one request present (combinational)
module arb_rr_nto1
  import mux_pkg::*;
#(
  parameter  int unsigned N_IN  = 4,
  localparam int unsigned SEL_W = clog2_min1(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  arb_mode_e        mode,
  input  logic [N_IN-1:0]  req,
  input  logic             advance,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [SEL_W-1:0] ptr_q;

  // Scan starting at ptr (RR) or 0 (fixed), wrapping modulo N_IN.
  always_comb begin
    int unsigned start;
    int unsigned idx;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    start     = (mode == MODE_RR) ? 32'(ptr_q) : 32'd0;
    idx       = 0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      idx = start + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!gnt_valid && (|(req & (N_IN'(1) << idx)))) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

  // Pointer moves past the winner only in RR mode; kept across mode changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && (mode == MODE_RR)) begin
      ptr_q <= (gnt_idx == SEL_W'(N_IN - 1)) ? '0 : gnt_idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// Arbitrated N-to-1 mux with a one-deep registered output stage.
//   i_clk, i_rst : clock, async active-high reset
//   i_mode       : 0 fixed priority, 1 round-robin
//   bus          : producer/consumer handshakes (see mux_arb_nto1_if)
// o_ready is combinational from i_valid and i_ready; everything else is
// registered.
module mux_arb_nto1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_IN  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_mode,
  mux_arb_nto1_if.slave bus
);

  localparam int unsigned SEL_W = clog2_min1(N_IN);

  out_state_e       state_q, state_d;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] data_sel;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic [N_IN-1:0]  ready_c;

  arb_rr_nto1 #(.N_IN(N_IN)) u_arb (
    .clk       (i_clk),
    .rst       (i_rst),
    .mode      (arb_mode_e'(i_mode)),
    .req       (bus.i_valid),
    .advance   (accept),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // A full register can take a new word in the same cycle it drains.
  assign can_accept = (state_q == ST_EMPTY) | bus.i_ready;
  assign accept     = gnt_valid & can_accept;

  // Data select and one-hot ready for the winner.
  always_comb begin
    data_sel = '0;
    ready_c  = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (gnt_idx == SEL_W'(k)) data_sel = bus.i_data[k*WIDTH +: WIDTH];
      ready_c[k] = accept & (gnt_idx == SEL_W'(k));
    end
  end

  // Output register occupancy: next-state.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_FULL;
    end else if ((state_q == ST_FULL) && bus.i_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Occupancy state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Payload register; holds its last word after draining.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
      sel_q  <= '0;
    end else if (accept) begin
      data_q <= data_sel;
      sel_q  <= gnt_idx;
    end
  end

  assign bus.o_ready = ready_c;
  assign bus.o_data  = data_q;
  assign bus.o_sel   = sel_q;
  assign bus.o_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux_arb_nto1.sv
module tb_mux_arb_nto1;
  import mux_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N4    = 4;
  localparam int unsigned N3    = 3;

  typedef struct {
    logic [31:0] data;
    int          sel;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode4;
  logic mode3;

  always #5 clk = ~clk;

  mux_arb_nto1_if #(.WIDTH(WIDTH), .N_IN(N4)) bus4 ();
  mux_arb_nto1_if #(.WIDTH(WIDTH), .N_IN(N3)) bus3 ();

  mux_arb_nto1 #(.WIDTH(WIDTH), .N_IN(N4)) dut4 (
    .i_clk (clk), .i_rst (rst), .i_mode (mode4), .bus (bus4.slave)
  );
  mux_arb_nto1 #(.WIDTH(WIDTH), .N_IN(N3)) dut3 (
    .i_clk (clk), .i_rst (rst), .i_mode (mode3), .bus (bus3.slave)
  );

  int checks = 0;
  int passed = 0;

  // Reference state: held word, occupancy and RR pointer.
  word_t       sb[$];
  bit          m_valid;
  logic [31:0] m_data;
  int          m_sel;
  int          m_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // First valid input scanning from the start point modulo N, or -1.
  function automatic int ref_grant(input logic [3:0] v, input logic md, input int p);
    int start;
    start = md ? p : 0;
    for (int k = 0; k < int'(N4); k++) begin
      if (v[(start + k) % N4]) return (start + k) % N4;
    end
    return -1;
  endfunction

  // One cycle of stimulus on the 4-input DUT with model update.
  task automatic cycle4(input logic [3:0] v, input logic md, input logic rdy, input logic [127:0] d);
    int         g;
    bit         acc;
    logic [3:0] exp_rdy;
    @(posedge clk); #1;
    bus4.i_valid = v;
    mode4        = md;
    bus4.i_ready = rdy;
    bus4.i_data  = d;
    #1;
    check("o_valid", 64'(bus4.o_valid), 64'(m_valid));
    check("o_data",  64'(bus4.o_data),  64'(m_data));
    check("o_sel",   64'(bus4.o_sel),   64'(m_sel));
    g       = ref_grant(v, md, m_ptr);
    acc     = (g >= 0) && (!m_valid || rdy);
    exp_rdy = acc ? 4'(1 << g) : 4'b0;
    check("o_ready", 64'(bus4.o_ready), 64'(exp_rdy));
    if (acc) begin
      word_t w;
      w.data  = d[g*32 +: 32];
      w.sel   = g;
      sb.push_back(w);
      m_data  = w.data;
      m_sel   = g;
      m_valid = 1'b1;
      if (md) m_ptr = (g + 1) % N4;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // Asynchronous reset in the middle of a cycle.
  task automatic do_reset();
    @(posedge clk); #3;
    rst          = 1'b1;
    bus4.i_valid = '0;
    bus4.i_ready = 1'b0;
    #1;
    check("rst_o_valid", 64'(bus4.o_valid), 64'd0);
    check("rst_o_data",  64'(bus4.o_data),  64'd0);
    check("rst_o_sel",   64'(bus4.o_sel),   64'd0);
    sb.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One cycle on the 3-input DUT with directed expectations.
  task automatic t3(input logic [2:0] v, input logic [2:0] exp_rdy, input int exp_sel, input logic exp_valid);
    bus3.i_valid = v;
    #1;
    check("n3_o_ready", 64'(bus3.o_ready), 64'(exp_rdy));
    @(posedge clk); #1;
    check("n3_o_valid", 64'(bus3.o_valid), 64'(exp_valid));
    check("n3_o_sel",   64'(bus3.o_sel),   64'(exp_sel));
  endtask

  // Consumer-side monitor: every word the consumer takes must be the oldest expected.
  always @(negedge clk) begin
    if (!rst && bus4.o_valid && bus4.i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL sb_underflow: output word %0h with nothing expected at %0t", bus4.o_data, $time);
      end else begin
        word_t w;
        w = sb.pop_front();
        check("sb_data", 64'(bus4.o_data), 64'(w.data));
        check("sb_sel",  64'(bus4.o_sel),  64'(w.sel));
      end
    end
  end

  initial begin
    logic [127:0] d;
    bus4.i_valid = '0; bus4.i_ready = 1'b0; bus4.i_data = '0; mode4 = 1'b0;
    bus3.i_valid = '0; bus3.i_ready = 1'b1; bus3.i_data = '0; mode3 = 1'b1;
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;

    // Reset values
    #12;
    check("init_o_valid", 64'(bus4.o_valid), 64'd0);
    check("init_o_data",  64'(bus4.o_data),  64'd0);
    check("init_o_sel",   64'(bus4.o_sel),   64'd0);
    check("init_o_ready", 64'(bus4.o_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fixed priority: input 1 always wins over input 3
    for (int i = 0; i < 6; i++) cycle4(4'b1010, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom});

    // Round-robin with all inputs valid
    for (int i = 0; i < 9; i++) cycle4(4'b1111, 1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});

    // Back-pressure with a known word from input 2, then replacement without a bubble
    d = {$urandom, $urandom, $urandom, $urandom};
    d[2*32 +: 32] = 32'hA5A5_0001;
    cycle4(4'b0100, 1'b1, 1'b1, d);
    for (int i = 0; i < 3; i++) cycle4(4'b1111, 1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
    cycle4(4'b0001, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
    cycle4(4'b0000, 1'b0, 1'b0, '0);

    // Drain to empty keeps the last data
    cycle4(4'b0001, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
    cycle4(4'b0000, 1'b0, 1'b1, '0);
    cycle4(4'b0000, 1'b0, 1'b1, '0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      cycle4(4'($urandom), 1'($urandom), 1'($urandom_range(3) != 0),
             {$urandom, $urandom, $urandom, $urandom});

    // Reset mid-stream with a held word, then RR restarts at input 0
    cycle4(4'b1110, 1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
    cycle4(4'b1111, 1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
    do_reset();
    for (int i = 0; i < 5; i++) cycle4(4'b1111, 1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});

    for (int i = 0; i < 200; i++)
      cycle4(4'($urandom), 1'($urandom), 1'($urandom_range(3) != 0),
             {$urandom, $urandom, $urandom, $urandom});
    cycle4(4'b0000, 1'b0, 1'b0, '0);
    check("sb_leftover", 64'(sb.size()), 64'(m_valid));

    // Three inputs: wrap from ptr 2 to input 0, then input 1
    @(posedge clk); #1;
    t3(3'b010, 3'b010, 1, 1'b1);
    t3(3'b011, 3'b001, 0, 1'b1);
    t3(3'b011, 3'b010, 1, 1'b1);
    t3(3'b000, 3'b000, 1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
